// File: rtl/dac_seq_pkg.sv
// Shared types and constants for the DAC burst trigger sequencer.
package dac_seq_pkg;

    localparam int unsigned DLY_W_DEF      = 11;
    localparam int unsigned PERIOD_W_DEF   = 16;
    localparam int unsigned BURST_W_DEF    = 16;
    // The generator counter saturates at this count; retriggering must wait one more cycle.
    localparam int unsigned GEN_SAT_CNT    = 1000;
    localparam int unsigned MIN_PERIOD_DEF = GEN_SAT_CNT + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_TAIL  = 2'd3
    } dac_seq_state_t;

endpackage

// File: rtl/dac_seq_edge.sv
// Trigger qualifier: rising edge of the synchronised external trigger ORed with the software trigger.
module dac_seq_edge (
    input  logic clk,
    input  logic reset,
    input  logic ext_trig,
    input  logic soft_trig,
    output logic trg_c
);

    logic ext_trig_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_trig_q <= 1'b0;
        end else begin
            ext_trig_q <= ext_trig;
        end
    end

    assign trg_c = (ext_trig & ~ext_trig_q) | soft_trig;

endmodule

// File: rtl/dac_trig_sequencer.sv
// Burst scheduler for the DAC clock generator: arm, wait for trigger, emit len pulses at a fixed period.
// Build option DAC_SEQ_AUTO_REARM_EN: return to ARMED (config retained) instead of IDLE after a burst.
module dac_trig_sequencer
    import dac_seq_pkg::*;
#(
    parameter int unsigned DLY_W      = DLY_W_DEF,
    parameter int unsigned PERIOD_W   = PERIOD_W_DEF,
    parameter int unsigned BURST_W    = BURST_W_DEF,
    parameter int unsigned MIN_PERIOD = MIN_PERIOD_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                arm,
    input  logic                abort,
    input  logic                ext_trig,
    input  logic                soft_trig,
    input  logic [DLY_W-1:0]    cfg_start_dly,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [BURST_W-1:0]  cfg_burst_len,
    output logic                dac_trig,
    output logic [DLY_W-1:0]    dac_start_dly,
    output logic                armed,
    output logic                busy,
    output logic                done,
    output logic                overrun,
    output logic [BURST_W-1:0]  pulse_cnt
);

    dac_seq_state_t      state;
    logic [PERIOD_W-1:0] per_l;
    logic [PERIOD_W-1:0] per_cnt;
    logic [BURST_W-1:0]  len_l;
    logic                trg_c;

    dac_seq_edge u_edge (
        .clk       (clk),
        .reset     (reset),
        .ext_trig  (ext_trig),
        .soft_trig (soft_trig),
        .trg_c     (trg_c)
    );

    // Sequencer FSM with period and pulse counters; dac_trig/done default low so they are single-cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            dac_trig      <= 1'b0;
            dac_start_dly <= '0;
            armed         <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            overrun       <= 1'b0;
            pulse_cnt     <= '0;
            per_l         <= PERIOD_W'(MIN_PERIOD);
            per_cnt       <= '0;
            len_l         <= BURST_W'(1);
        end else begin
            dac_trig <= 1'b0;
            done     <= 1'b0;
            if (abort) begin
                state <= ST_IDLE;
                armed <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (arm) begin
                            state         <= ST_ARMED;
                            armed         <= 1'b1;
                            dac_start_dly <= cfg_start_dly;
                            per_l         <= (cfg_period < PERIOD_W'(MIN_PERIOD)) ?
                                             PERIOD_W'(MIN_PERIOD) : cfg_period;
                            len_l         <= (cfg_burst_len == '0) ? BURST_W'(1) : cfg_burst_len;
                            pulse_cnt     <= '0;
                            overrun       <= 1'b0;
                        end
                    end
                    ST_ARMED: begin
                        if (trg_c) begin
                            state     <= ST_RUN;
                            armed     <= 1'b0;
                            busy      <= 1'b1;
                            dac_trig  <= 1'b1;
                            pulse_cnt <= BURST_W'(1);
                            per_cnt   <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (trg_c) begin
                            overrun <= 1'b1;
                        end
                        if (per_cnt == per_l - PERIOD_W'(1)) begin
                            per_cnt <= '0;
                            if (pulse_cnt < len_l) begin
                                dac_trig  <= 1'b1;
                                pulse_cnt <= pulse_cnt + BURST_W'(1);
                            end else begin
                                // done is visible during the single TAIL cycle, per_l after the last pulse
                                state <= ST_TAIL;
                                done  <= 1'b1;
                            end
                        end else begin
                            per_cnt <= per_cnt + PERIOD_W'(1);
                        end
                    end
                    ST_TAIL: begin
                        if (trg_c) begin
                            overrun <= 1'b1;
                        end
                        busy <= 1'b0;
`ifdef DAC_SEQ_AUTO_REARM_EN
                        state     <= ST_ARMED;
                        armed     <= 1'b1;
                        pulse_cnt <= '0;
`else
                        state     <= ST_IDLE;
`endif
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dac_trig_sequencer.sv
// Self-checking bench for dac_trig_sequencer: burst vector table plus abort, reset and overrun sequences.
module tb_dac_trig_sequencer;
    import dac_seq_pkg::*;

    logic                    clk;
    logic                    reset;
    logic                    arm;
    logic                    abort;
    logic                    ext_trig;
    logic                    soft_trig;
    logic [DLY_W_DEF-1:0]    cfg_start_dly;
    logic [PERIOD_W_DEF-1:0] cfg_period;
    logic [BURST_W_DEF-1:0]  cfg_burst_len;
    logic                    dac_trig;
    logic [DLY_W_DEF-1:0]    dac_start_dly;
    logic                    armed;
    logic                    busy;
    logic                    done;
    logic                    overrun;
    logic [BURST_W_DEF-1:0]  pulse_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int dly;
        int period;
        int len;
        bit use_ext;
        int inject;     // cycle offset of an ext_trig rise during the burst, 0 = none
        int exp_per;
        int exp_len;
        int exp_ovr;
    } vec_t;

    vec_t vecs[6];

`ifdef DAC_SEQ_AUTO_REARM_EN
    localparam int EXP_REARM = 1;
`else
    localparam int EXP_REARM = 0;
`endif

    dac_trig_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .arm           (arm),
        .abort         (abort),
        .ext_trig      (ext_trig),
        .soft_trig     (soft_trig),
        .cfg_start_dly (cfg_start_dly),
        .cfg_period    (cfg_period),
        .cfg_burst_len (cfg_burst_len),
        .dac_trig      (dac_trig),
        .dac_start_dly (dac_start_dly),
        .armed         (armed),
        .busy          (busy),
        .done          (done),
        .overrun       (overrun),
        .pulse_cnt     (pulse_cnt)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    initial begin
        #(8 * 90000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_burst(input vec_t v);
        int npulse, bad_pulse, ndone, done_t, dly_bad, cnt_at_done, busy_at_done, limit;
        npulse = 0; bad_pulse = 0; ndone = 0; done_t = -1; dly_bad = 0;
        cnt_at_done = -1; busy_at_done = 0;
        abort = 1'b1; step(); abort = 1'b0;
        cfg_start_dly = DLY_W_DEF'(v.dly);
        cfg_period    = PERIOD_W_DEF'(v.period);
        cfg_burst_len = BURST_W_DEF'(v.len);
        arm = 1'b1; step(); arm = 1'b0;
        check("armed_after_arm", int'(armed), 1);
        check("overrun_cleared_on_arm", int'(overrun), 0);
        check("pulse_cnt_cleared_on_arm", int'(pulse_cnt), 0);
        if (v.use_ext) ext_trig = 1'b1; else soft_trig = 1'b1;
        step(); soft_trig = 1'b0;
        check("first_trig_latency", int'(dac_trig), 1);
        check("busy_with_first_trig", int'(busy), 1);
        limit = 1 + v.exp_len * v.exp_per + 1;
        for (int t = 1; t <= limit; t++) begin
            if (dac_trig) begin
                if (npulse < v.exp_len && t == 1 + npulse * v.exp_per) npulse++;
                else bad_pulse++;
            end
            if (done) begin
                ndone++;
                done_t = t;
                cnt_at_done = int'(pulse_cnt);
                busy_at_done = int'(busy);
            end
            if (dac_start_dly != DLY_W_DEF'(v.dly)) dly_bad++;
            if (t == limit) begin
                check("armed_after_done", int'(armed), EXP_REARM);
                check("busy_after_done", int'(busy), 0);
            end
            ext_trig = (v.inject != 0 && t == v.inject);
            step();
        end
        check("pulse_count_seen", npulse, v.exp_len);
        check("misplaced_pulses", bad_pulse, 0);
        check("done_pulses", ndone, 1);
        check("done_time", done_t, 1 + v.exp_len * v.exp_per);
        check("pulse_cnt_at_done", cnt_at_done, v.exp_len);
        check("busy_at_done", busy_at_done, 1);
        check("start_dly_stable", dly_bad, 0);
        check("overrun_flag", int'(overrun), v.exp_ovr);
    endtask

    initial begin
        int ntrig, ndone;
        vecs[0] = '{dly: 100,  period: 2000, len: 3, use_ext: 1'b1, inject: 0,  exp_per: 2000, exp_len: 3, exp_ovr: 0};
        vecs[1] = '{dly: 7,    period: 500,  len: 2, use_ext: 1'b0, inject: 0,  exp_per: 1001, exp_len: 2, exp_ovr: 0};
        vecs[2] = '{dly: 2047, period: 0,    len: 0, use_ext: 1'b0, inject: 0,  exp_per: 1001, exp_len: 1, exp_ovr: 0};
        vecs[3] = '{dly: 0,    period: 1001, len: 2, use_ext: 1'b1, inject: 10, exp_per: 1001, exp_len: 2, exp_ovr: 1};
        vecs[4] = '{dly: 5,    period: 1002, len: 1, use_ext: 1'b1, inject: 0,  exp_per: 1002, exp_len: 1, exp_ovr: 0};
        vecs[5] = '{dly: 33,   period: 1500, len: 2, use_ext: 1'b0, inject: 0,  exp_per: 1500, exp_len: 2, exp_ovr: 0};

        reset = 1'b1; arm = 1'b0; abort = 1'b0; ext_trig = 1'b0; soft_trig = 1'b0;
        cfg_start_dly = '0; cfg_period = '0; cfg_burst_len = '0;
        #20;
        check("reset_dac_trig", int'(dac_trig), 0);
        check("reset_armed", int'(armed), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_overrun", int'(overrun), 0);
        check("reset_start_dly", int'(dac_start_dly), 0);
        check("reset_pulse_cnt", int'(pulse_cnt), 0);
        step(); reset = 1'b0; step();

        // Trigger in IDLE is ignored and sets no flag
        soft_trig = 1'b1; step(); soft_trig = 1'b0;
        check("idle_trig_no_pulse", int'(dac_trig), 0);
        step();
        check("idle_trig_no_overrun", int'(overrun), 0);
        check("idle_trig_not_busy", int'(busy), 0);

        for (int i = 0; i < 6; i++) begin
            run_burst(vecs[i]);
`ifdef DAC_SEQ_AUTO_REARM_EN
            soft_trig = 1'b1; step(); soft_trig = 1'b0;
            check("rearm_new_burst_trig", int'(dac_trig), 1);
            check("rearm_new_burst_cnt", int'(pulse_cnt), 1);
`endif
        end

        // Abort one cycle after the second pulse of a len=5 burst
        abort = 1'b1; step(); abort = 1'b0;
        cfg_start_dly = 11'd9; cfg_period = 16'd1001; cfg_burst_len = 16'd5;
        arm = 1'b1; step(); arm = 1'b0;
        soft_trig = 1'b1; step(); soft_trig = 1'b0;
        repeat (1001) step();
        check("abort_second_pulse", int'(dac_trig), 1);
        check("abort_cnt_before", int'(pulse_cnt), 2);
        step();
        abort = 1'b1; step(); abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_armed", int'(armed), 0);
        check("abort_cnt_held", int'(pulse_cnt), 2);
        check("abort_no_done", int'(done), 0);
        ntrig = 0; ndone = 0;
        for (int t = 0; t < 1100; t++) begin
            if (dac_trig) ntrig++;
            if (done) ndone++;
            step();
        end
        check("abort_no_more_trig", ntrig, 0);
        check("abort_no_late_done", ndone, 0);
        check("abort_cnt_still_held", int'(pulse_cnt), 2);

        // arm together with abort in IDLE: abort wins
        arm = 1'b1; abort = 1'b1; step(); arm = 1'b0; abort = 1'b0;
        check("arm_abort_stays_idle", int'(armed), 0);
        step();
        check("arm_abort_still_idle", int'(armed), 0);

        // Asynchronous reset while a trigger pulse is high
        cfg_start_dly = 11'd321; cfg_period = 16'd1200; cfg_burst_len = 16'd4;
        arm = 1'b1; step(); arm = 1'b0;
        ext_trig = 1'b1; step(); ext_trig = 1'b0;
        check("pre_reset_trig", int'(dac_trig), 1);
        reset = 1'b1; #1;
        check("midrun_reset_dac_trig", int'(dac_trig), 0);
        check("midrun_reset_busy", int'(busy), 0);
        check("midrun_reset_pulse_cnt", int'(pulse_cnt), 0);
        check("midrun_reset_start_dly", int'(dac_start_dly), 0);
        step(); reset = 1'b0;
        repeat (1300) begin
            step();
            if (dac_trig) check("post_reset_no_trig", int'(dac_trig), 0);
        end
        check("post_reset_idle", int'(armed) + int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dac_trig_sequencer.md
# dac_trig_sequencer

Burst scheduler for the DAC clock generator. Arms on host command, waits for an external or software trigger, then emits a programmable number of one-cycle `dac_trig` pulses at a fixed period. It presents a burst-stable `dac_start_dly` to the generator. Sits between the host register block / timing-system trigger input and the DAC clock generator, in the 125 MHz `clk` domain.

## Interface
- `DLY_W`, 11: width of start delay, matches the generator's counter.
- `PERIOD_W`, 16: period counter width.
- `BURST_W`, 16: burst length and pulse count width.
- `MIN_PERIOD`, 1001: minimum trigger spacing in clk cycles, so the generator counter reaches saturation (1000) before retrigger.

Ports:
- `clk` in 1: 125 MHz clock.
- `reset` in 1: asynchronous, active-high.
- `arm` in 1: one-cycle arm request.
- `abort` in 1: one-cycle abort request.
- `ext_trig` in 1: level trigger, already synchronised to `clk`; rising edge is used.
- `soft_trig` in 1: one-cycle software trigger.
- `cfg_start_dly` in DLY_W: start delay, sampled on arm.
- `cfg_period` in PERIOD_W: pulse spacing, sampled on arm.
- `cfg_burst_len` in BURST_W: pulses per burst, sampled on arm.
- `dac_trig` out 1: one-cycle trigger to the clock generator.
- `dac_start_dly` out DLY_W: latched start delay to the generator.
- `armed` out 1: high in ARMED.
- `busy` out 1: high in RUN and TAIL.
- `done` out 1: one-cycle pulse at burst completion.
- `overrun` out 1: sticky flag; a trigger arrived while busy.
- `pulse_cnt` out BURST_W: pulses issued in the current burst.

## Operation
- States: IDLE, ARMED, RUN, TAIL.
- IDLE → ARMED on `arm`. On that transition:
  - Latch `dly_l = cfg_start_dly`.
  - Latch `per_l = max(cfg_period, MIN_PERIOD)`.
  - Latch `len_l = (cfg_burst_len == 0) ? 1 : cfg_burst_len`.
  - Clear `pulse_cnt` and `overrun`.
- ARMED → RUN on `trg = (ext_trig & ~ext_trig_q) | soft_trig`. Registered `dac_trig` fires, `pulse_cnt` = 1, and the period counter loads 0.
- RUN: the period counter increments every cycle. At `per_l-1`:
  - If `pulse_cnt < len_l`: fire `dac_trig`, increment `pulse_cnt`, counter returns to 0.
  - Else: go to TAIL.
- TAIL: hold for the remainder, then pulse `done` and go to IDLE. `done` lands exactly `per_l` cycles after the last `dac_trig`.
- `trg` while RUN or TAIL: set `overrun`, otherwise ignored.
- `trg` in IDLE: ignored, no flag.
- `abort` in any state: IDLE on the next cycle, no `done`, no further `dac_trig`. `pulse_cnt` and `overrun` are held.
- `arm` outside IDLE is ignored. `arm` and `abort` in the same cycle: abort wins.
- `dac_start_dly` updates only on arm. It is constant through the burst.
- Period counter and `pulse_cnt` never wrap: `per_l` and `len_l` fit their widths by construction.

## Timing
- Reset values:
  - State IDLE.
  - `dac_trig`, `armed`, `busy`, `done`, `overrun`: 0.
  - `dac_start_dly` and `pulse_cnt`: 0.
  - `ext_trig_q`: 0.
- All outputs are registered.
- Latency: `ext_trig` rising at cycle k (sampled at edge k) gives `dac_trig` high in cycle k+1. `soft_trig` has the same latency.
- Spacing between consecutive `dac_trig` pulses: exactly `per_l` cycles.
- `armed` rises 1 cycle after `arm`. `busy` rises together with the first `dac_trig`.
- `done` falls with `busy` in the same cycle.
- Reset mid-burst: outputs go to reset values asynchronously. `dac_trig` never extends past 1 cycle.

## Configuration
- Macro: `DAC_SEQ_AUTO_REARM_EN`.
  - Defined: TAIL end pulses `done` and returns to ARMED rather than IDLE. `pulse_cnt` is cleared, latched config is retained, `overrun` is kept.
  - Undefined: TAIL end returns to IDLE, and a new `arm` is required.

## Structure
- Shared package `dac_seq_pkg`:
  - State enum `dac_seq_state_t`.
  - Default `MIN_PERIOD` constant (1001).
  - Generator saturation constant (1000).
  - Default widths.
- One sub-module, `dac_seq_edge`: registered rising-edge detector on `ext_trig`, ORed with `soft_trig`, producing `trg`.
- The FSM, period counter and pulse counter stay in the top level.

## Test plan
- Arm with dly=100, period=2000, len=3, then ext_trig rise at cycle 50. Expect: `dac_trig` at 51, 2051 and 4051; `done` at 6051; `pulse_cnt`=3; `dac_start_dly`=100 throughout.
- Arm with period=500, len=2, then soft_trig. Expect: pulses spaced 1001 cycles (clamped).
- Arm with len=0. Expect: exactly one `dac_trig`, then `done` 1001+ cycles later.
- ext_trig rise during RUN. Expect: `overrun`=1, pulse timing unchanged. Next `arm` clears `overrun`.
- `abort` one cycle after the second pulse of a len=5 burst. Expect: IDLE next cycle, no `done`, `pulse_cnt`=2. Simultaneous arm+abort in IDLE: stays IDLE.
- Reset asserted mid-RUN. Expect: all outputs 0 immediately. With `DAC_SEQ_AUTO_REARM_EN`: `armed`=1 in the cycle after `done`, and a second trigger starts a new burst.
